ofm_frame_fifo: RTL and testbench
=================================

// Module: ofm_frame_fifo
// PURPOSE
//  Single-clock, parametrised store-and-forward queue pair for the outbound frame (OFM) path.
//  Carries a descriptor (ctrl) queue and a frame-data queue in the mm2s domain.
//  Data beats only become visible to the reader when their frame is committed by a last beat.
//  A frame is rolled back if it is aborted or if it overflows.
// PARAMETERS
//  CW        64   ctrl word width (bits)
//  CAW       8    ctrl queue address width; depth = 2**CAW
//  DW        73   data word width (bits); user packs keep/last into the word
//  DAW       9    data queue address width; depth = 2**DAW
//  C_AFULL   2**CAW-4   ctrl almost-full threshold (entries used)
//  D_AFULL   2**DAW-16  data almost-full threshold (entries used, speculative pointer)
// PORTS
//  mm2s_clk         in   1      clock, all logic rising edge
//  mm2s_resetn      in   1      asynchronous active-low reset
//  ctrl_fifo_wdata  in   CW     descriptor to push
//  ctrl_fifo_wren   in   1      push descriptor
//  ctrl_fifo_afull  out  1      ctrl used >= C_AFULL
//  ctrl_fifo_rdata  out  CW     descriptor read data (registered)
//  ctrl_fifo_empty  out  1      no descriptors
//  ctrl_fifo_rden   in   1      pop descriptor
//  data_fifo_wdata  in   DW     data beat
//  data_fifo_wren   in   1      push beat
//  data_fifo_wlast  in   1      beat is last of frame; commit on accept
//  data_fifo_abort  in   1      discard uncommitted beats of current frame
//  data_fifo_afull  out  1      speculative used >= D_AFULL
//  data_fifo_rdata  out  DW     data read data (registered)
//  data_fifo_empty  out  1      no committed beats
//  data_fifo_rden   in   1      pop beat
// BEHAVIOUR
//  Reset: all pointers 0; *_empty=1; *_afull=0; *_rdata=0; all stats=0.
//  Reset is honoured mid-frame: uncommitted data is lost.
//  Pointers are (AW+1) bits; the MSB differs when full. Wrap-around is natural binary rollover.
//  Ctrl queue: plain FIFO.
//   - Push is accepted when wren && !full; pop is accepted when rden && !empty.
//   - rdata loads the head entry on the edge where the pop is accepted (1-cycle latency).
//   - Push to full and pop from empty are ignored; state is unchanged.
//   - Simultaneous push and pop are both accepted, so used is unchanged.
//  Data queue uses three pointers: wr_spec, wr_commit, rd.
//   - Accepted write (wren && !full && !bad): store at wr_spec, wr_spec++.
//     If wlast is also set, wr_commit <= wr_spec+1 in the same edge.
//   - empty = (rd == wr_commit). A committed beat is readable the cycle after the commit edge.
//   - full = wr_spec - rd == 2**DAW. Writing while full sets the internal bad flag.
//   - bad set: further beats of the frame are dropped.
//     At the wlast beat, wr_spec <= wr_commit (rollback) and bad clears.
//   - abort: wr_spec <= wr_commit next edge, bad clears.
//     If abort and wren are in the same cycle, abort wins and the beat is dropped.
//   - Read: same rules as ctrl, with 1-cycle latency.
//     Reads never pass wr_commit, even when wr_spec is ahead.
//   - afull is computed from wr_spec - rd and registered (1-cycle lag).
//     The writer therefore needs >= 2 entries of slack above the threshold.
//   - A frame longer than 2**DAW beats always rolls back. The queue never deadlocks.
// CONFIGURATION
//  Macro OFM_FIFO_STATS_EN.
//  Defined: adds outputs
//   - stat_frames[31:0]: committed frames, incremented on each accepted wlast commit.
//   - stat_drops[31:0]: rolled-back frames, counting abort or overflow rollback.
//   - stat_ovf: sticky, set on write-while-full, cleared only by reset.
//  Counters wrap at 2**32.
//  Undefined: these ports and their logic are absent. Data-path behaviour is identical.
// STRUCTURE
//  Package ofm_fifo_pkg holds:
//   - OFM_CTRL_W=64 and OFM_DATA_W=73
//   - the bit positions of last/keep inside the data word
//   - the default depth constants.
//  Sub-module ofm_sync_fifo: generic single-clock FIFO (DW, AW, AFULL) with registered read.
//  It is instantiated for the ctrl queue.
//  The data queue is coded inline, because the commit/rollback pointers do not fit the generic FIFO.
//  Storage is an inferred simple-dual-port RAM, one write port and one read port.
// TESTING
//  1. Push 3 ctrl words 0x1,0x2,0x3, then pop 3 -> rdata 1,2,3 each one cycle after rden.
//     empty=1 after the third pop.
//  2. Write 4 data beats with wlast only on beat 4 -> empty stays 1 through beat 3.
//     empty falls the cycle after beat 4; 4 reads return the beats in order.
//  3. Write 5 beats, assert abort, then write a 2-beat frame -> reader sees only the 2 beats.
//     stat_drops=1 when OFM_FIFO_STATS_EN is defined.
//  4. DAW=4: write a 20-beat frame with no reads -> full at 16, bad set, rollback at wlast.
//     empty=1; stat_ovf=1.
//  5. Fill ctrl to C_AFULL-1 then push 1 -> afull=1 one cycle later.
//     Simultaneous push and pop at full -> used unchanged, afull held.
//  6. Assert mm2s_resetn low mid-frame with 3 committed beats -> all outputs at reset values immediately.
//     After release, a new 1-beat frame reads correctly.

Source files
------------

// File: rtl/ofm_fifo_pkg.sv
// Shared widths, data-word field positions and default depths for the outbound frame FIFO pair.
package ofm_fifo_pkg;

   localparam int OFM_CTRL_W   = 64;
   localparam int OFM_DATA_W   = 73;
   localparam int OFM_CTRL_AW  = 8;
   localparam int OFM_DATA_AW  = 9;

   // Data word layout: {last, keep[7:0], payload[63:0]}
   localparam int OFM_LAST_BIT = 72;
   localparam int OFM_KEEP_LSB = 64;
   localparam int OFM_KEEP_W   = 8;

   typedef struct packed {
      logic                  last;
      logic [OFM_KEEP_W-1:0] keep;
      logic [63:0]           dat;
   } ofm_beat_t;

endpackage

// File: rtl/ofm_sync_fifo.sv
// Generic single-clock FIFO with registered read data; afull is registered from the used count.
// Latency: pushed word is poppable next cycle, rdata valid one cycle after the accepted pop.
module ofm_sync_fifo #(
   parameter int DW    = 64,
   parameter int AW    = 8,
   parameter int AFULL = 2**AW - 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] wdata,
   input  logic          wren,
   input  logic          rden,
   output logic [DW-1:0] rdata,
   output logic          empty,
   output logic          afull
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(2**AW);
   localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL);

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wr_q, wr_d, rd_q, rd_d, used;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          afull_q, afull_d;
   logic          full, push, pop;

   always_comb begin
      used    = wr_q - rd_q;
      full    = (used == DEPTH_L);
      empty   = (wr_q == rd_q);
      push    = wren && !full;
      pop     = rden && !empty;
      wr_d    = wr_q + {{AW{1'b0}}, push};
      rd_d    = rd_q + {{AW{1'b0}}, pop};
      rdata_d = pop ? mem[rd_q[AW-1:0]] : rdata_q;
      afull_d = (used >= AFULL_L);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
         afull_q <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
         afull_q <= afull_d;
      end
   end

   assign rdata = rdata_q;
   assign afull = afull_q;

endmodule

// File: rtl/ofm_frame_fifo.sv
// Descriptor FIFO plus store-and-forward frame-data FIFO; data is visible only once a frame commits.
// Optional statistics outputs are built when OFM_FIFO_STATS_EN is defined.
module ofm_frame_fifo
   import ofm_fifo_pkg::*;
#(
   parameter int CW      = OFM_CTRL_W,
   parameter int CAW     = OFM_CTRL_AW,
   parameter int DW      = OFM_DATA_W,
   parameter int DAW     = OFM_DATA_AW,
   parameter int C_AFULL = 2**CAW - 4,
   parameter int D_AFULL = 2**DAW - 16
) (
   input  logic          mm2s_clk,
   input  logic          mm2s_resetn,
   input  logic [CW-1:0] ctrl_fifo_wdata,
   input  logic          ctrl_fifo_wren,
   output logic          ctrl_fifo_afull,
   output logic [CW-1:0] ctrl_fifo_rdata,
   output logic          ctrl_fifo_empty,
   input  logic          ctrl_fifo_rden,
   input  logic [DW-1:0] data_fifo_wdata,
   input  logic          data_fifo_wren,
   input  logic          data_fifo_wlast,
   input  logic          data_fifo_abort,
   output logic          data_fifo_afull,
   output logic [DW-1:0] data_fifo_rdata,
   output logic          data_fifo_empty,
   input  logic          data_fifo_rden
`ifdef OFM_FIFO_STATS_EN
  ,output logic [31:0]   stat_frames
  ,output logic [31:0]   stat_drops
  ,output logic          stat_ovf
`endif
);

   ofm_sync_fifo #(
      .DW    (CW),
      .AW    (CAW),
      .AFULL (C_AFULL)
   ) u_ctrl_fifo (
      .clk   (mm2s_clk),
      .rst_n (mm2s_resetn),
      .wdata (ctrl_fifo_wdata),
      .wren  (ctrl_fifo_wren),
      .rden  (ctrl_fifo_rden),
      .rdata (ctrl_fifo_rdata),
      .empty (ctrl_fifo_empty),
      .afull (ctrl_fifo_afull)
   );

   localparam logic [DAW:0] D_DEPTH_L = (DAW+1)'(2**DAW);
   localparam logic [DAW:0] D_AFULL_L = (DAW+1)'(D_AFULL);

   logic [DW-1:0] mem [2**DAW];
   logic [DAW:0]  wr_spec_q, wr_spec_d, wr_cmt_q, wr_cmt_d, rd_q, rd_d, spec_used;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          bad_q, bad_d, afull_q, afull_d;
   logic          full, empty, wr_ok, commit, ovf_ev, rollback, pop;

   always_comb begin
      wr_spec_d = wr_spec_q;
      wr_cmt_d  = wr_cmt_q;
      bad_d     = bad_q;
      spec_used = wr_spec_q - rd_q;
      full      = (spec_used == D_DEPTH_L);
      empty     = (rd_q == wr_cmt_q);
      wr_ok     = data_fifo_wren && !data_fifo_abort && !full && !bad_q;
      commit    = wr_ok && data_fifo_wlast;
      ovf_ev    = data_fifo_wren && !data_fifo_abort && full;
      // An overflowed frame (already bad, or hitting full on its last beat) unwinds at wlast.
      rollback  = data_fifo_abort ||
                  (data_fifo_wren && data_fifo_wlast && (bad_q || full));

      if (wr_ok)  wr_spec_d = wr_spec_q + {{DAW{1'b0}}, 1'b1};
      if (commit) wr_cmt_d  = wr_spec_q + {{DAW{1'b0}}, 1'b1};
      if (rollback) begin
         wr_spec_d = wr_cmt_q;
         bad_d     = 1'b0;
      end else if (ovf_ev) begin
         bad_d     = 1'b1;
      end

      pop     = data_fifo_rden && !empty;
      rd_d    = rd_q + {{DAW{1'b0}}, pop};
      rdata_d = pop ? mem[rd_q[DAW-1:0]] : rdata_q;
      afull_d = (spec_used >= D_AFULL_L);
   end

   always_ff @(posedge mm2s_clk) begin
      if (wr_ok) mem[wr_spec_q[DAW-1:0]] <= data_fifo_wdata;
   end

   always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         wr_spec_q <= '0;
         wr_cmt_q  <= '0;
         rd_q      <= '0;
         bad_q     <= 1'b0;
         rdata_q   <= '0;
         afull_q   <= 1'b0;
      end else begin
         wr_spec_q <= wr_spec_d;
         wr_cmt_q  <= wr_cmt_d;
         rd_q      <= rd_d;
         bad_q     <= bad_d;
         rdata_q   <= rdata_d;
         afull_q   <= afull_d;
      end
   end

   assign data_fifo_rdata = rdata_q;
   assign data_fifo_empty = empty;
   assign data_fifo_afull = afull_q;

`ifdef OFM_FIFO_STATS_EN
   logic [31:0] frames_q, frames_d, drops_q, drops_d;
   logic        ovf_q, ovf_d, drop_ev;

   always_comb begin
      // An abort with nothing pending is not a dropped frame.
      drop_ev  = rollback &&
                 (!data_fifo_abort || bad_q || (wr_spec_q != wr_cmt_q));
      frames_d = frames_q + {31'd0, commit};
      drops_d  = drops_q + {31'd0, drop_ev};
      ovf_d    = ovf_q | ovf_ev;
   end

   always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         frames_q <= '0;
         drops_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         frames_q <= frames_d;
         drops_q  <= drops_d;
         ovf_q    <= ovf_d;
      end
   end

   assign stat_frames = frames_q;
   assign stat_drops  = drops_q;
   assign stat_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_ofm_frame_fifo.sv
// Directed bench for ofm_frame_fifo: vector table for basic ctrl/data flow, hand sequences for corners.
module tb_ofm_frame_fifo;

   localparam int CW  = 64;
   localparam int DW  = 73;
   localparam int CAW = 4;
   localparam int DAW = 4;
   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   logic          mm2s_clk = 1'b0;
   logic          mm2s_resetn;
   logic [CW-1:0] ctrl_fifo_wdata;
   logic          ctrl_fifo_wren;
   logic          ctrl_fifo_afull;
   logic [CW-1:0] ctrl_fifo_rdata;
   logic          ctrl_fifo_empty;
   logic          ctrl_fifo_rden;
   logic [DW-1:0] data_fifo_wdata;
   logic          data_fifo_wren;
   logic          data_fifo_wlast;
   logic          data_fifo_abort;
   logic          data_fifo_afull;
   logic [DW-1:0] data_fifo_rdata;
   logic          data_fifo_empty;
   logic          data_fifo_rden;
`ifdef OFM_FIFO_STATS_EN
   logic [31:0]   stat_frames;
   logic [31:0]   stat_drops;
   logic          stat_ovf;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 mm2s_clk = ~mm2s_clk;

   ofm_frame_fifo #(
      .CW      (CW),
      .CAW     (CAW),
      .DW      (DW),
      .DAW     (DAW),
      .D_AFULL (12)
   ) dut (
      .mm2s_clk        (mm2s_clk),
      .mm2s_resetn     (mm2s_resetn),
      .ctrl_fifo_wdata (ctrl_fifo_wdata),
      .ctrl_fifo_wren  (ctrl_fifo_wren),
      .ctrl_fifo_afull (ctrl_fifo_afull),
      .ctrl_fifo_rdata (ctrl_fifo_rdata),
      .ctrl_fifo_empty (ctrl_fifo_empty),
      .ctrl_fifo_rden  (ctrl_fifo_rden),
      .data_fifo_wdata (data_fifo_wdata),
      .data_fifo_wren  (data_fifo_wren),
      .data_fifo_wlast (data_fifo_wlast),
      .data_fifo_abort (data_fifo_abort),
      .data_fifo_afull (data_fifo_afull),
      .data_fifo_rdata (data_fifo_rdata),
      .data_fifo_empty (data_fifo_empty),
      .data_fifo_rden  (data_fifo_rden)
`ifdef OFM_FIFO_STATS_EN
     ,.stat_frames     (stat_frames)
     ,.stat_drops      (stat_drops)
     ,.stat_ovf        (stat_ovf)
`endif
   );

   typedef struct {
      logic          c_wr;
      logic          c_rd;
      logic [CW-1:0] c_dat;
      logic          d_wr;
      logic          d_last;
      logic          d_rd;
      logic [DW-1:0] d_dat;
      logic          x_cempty;
      logic          x_dempty;
      logic          chk_c;
      logic [CW-1:0] x_crd;
      logic          chk_d;
      logic [DW-1:0] x_drd;
   } vec_t;

   vec_t tv[15];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge mm2s_clk);
      #1;
   endtask

   task automatic idle_inputs();
      ctrl_fifo_wdata = '0;
      ctrl_fifo_wren  = 1'b0;
      ctrl_fifo_rden  = 1'b0;
      data_fifo_wdata = '0;
      data_fifo_wren  = 1'b0;
      data_fifo_wlast = 1'b0;
      data_fifo_abort = 1'b0;
      data_fifo_rden  = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " c_empty"}, 128'(ctrl_fifo_empty), 128'(1'b1));
      check({tag, " d_empty"}, 128'(data_fifo_empty), 128'(1'b1));
      check({tag, " c_afull"}, 128'(ctrl_fifo_afull), 128'(1'b0));
      check({tag, " d_afull"}, 128'(data_fifo_afull), 128'(1'b0));
      check({tag, " c_rdata"}, 128'(ctrl_fifo_rdata), 128'(0));
      check({tag, " d_rdata"}, 128'(data_fifo_rdata), 128'(0));
`ifdef OFM_FIFO_STATS_EN
      check({tag, " frames"}, 128'(stat_frames), 128'(0));
      check({tag, " drops"},  128'(stat_drops),  128'(0));
      check({tag, " ovf"},    128'(stat_ovf),    128'(1'b0));
`endif
   endtask

   task automatic data_write(input logic [DW-1:0] d, input logic last);
      data_fifo_wren  = 1'b1;
      data_fifo_wdata = d;
      data_fifo_wlast = last;
      step();
      data_fifo_wren  = 1'b0;
      data_fifo_wlast = 1'b0;
   endtask

   task automatic data_read(input string nm, input logic [DW-1:0] x, input logic x_empty);
      data_fifo_rden = 1'b1;
      step();
      data_fifo_rden = 1'b0;
      check({nm, " rdata"}, 128'(data_fifo_rdata), 128'(x));
      check({nm, " empty"}, 128'(data_fifo_empty), 128'(x_empty));
   endtask

   initial begin
      logic [CW-1:0] cexp;

      idle_inputs();
      mm2s_resetn = 1'b0;
      repeat (2) @(posedge mm2s_clk);
      #1;
      check_reset_state("reset");
      #3 mm2s_resetn = 1'b1;

      // ctrl push 1,2,3 then pop; data 4-beat frame committed on beat 4, then read back
      tv[0]  = '{Y, N, 64'h1, N, N, N, 73'h0,  N, Y, N, 64'h0, N, 73'h0};
      tv[1]  = '{Y, N, 64'h2, N, N, N, 73'h0,  N, Y, N, 64'h0, N, 73'h0};
      tv[2]  = '{Y, N, 64'h3, N, N, N, 73'h0,  N, Y, N, 64'h0, N, 73'h0};
      tv[3]  = '{N, Y, 64'h0, N, N, N, 73'h0,  N, Y, Y, 64'h1, N, 73'h0};
      tv[4]  = '{N, Y, 64'h0, N, N, N, 73'h0,  N, Y, Y, 64'h2, N, 73'h0};
      tv[5]  = '{N, Y, 64'h0, N, N, N, 73'h0,  Y, Y, Y, 64'h3, N, 73'h0};
      tv[6]  = '{N, N, 64'h0, N, N, N, 73'h0,  Y, Y, Y, 64'h3, N, 73'h0};
      tv[7]  = '{N, N, 64'h0, Y, N, N, 73'hA1, Y, Y, N, 64'h0, N, 73'h0};
      tv[8]  = '{N, N, 64'h0, Y, N, N, 73'hA2, Y, Y, N, 64'h0, N, 73'h0};
      tv[9]  = '{N, N, 64'h0, Y, N, N, 73'hA3, Y, Y, N, 64'h0, N, 73'h0};
      tv[10] = '{N, N, 64'h0, Y, Y, N, {1'b1, 8'hFF, 64'hA4}, Y, N, N, 64'h0, N, 73'h0};
      tv[11] = '{N, N, 64'h0, N, N, Y, 73'h0,  Y, N, N, 64'h0, Y, 73'hA1};
      tv[12] = '{N, N, 64'h0, N, N, Y, 73'h0,  Y, N, N, 64'h0, Y, 73'hA2};
      tv[13] = '{N, N, 64'h0, N, N, Y, 73'h0,  Y, N, N, 64'h0, Y, 73'hA3};
      tv[14] = '{N, N, 64'h0, N, N, Y, 73'h0,  Y, Y, N, 64'h0, Y, {1'b1, 8'hFF, 64'hA4}};

      for (int i = 0; i < 15; i++) begin
         ctrl_fifo_wren  = tv[i].c_wr;
         ctrl_fifo_rden  = tv[i].c_rd;
         ctrl_fifo_wdata = tv[i].c_dat;
         data_fifo_wren  = tv[i].d_wr;
         data_fifo_wlast = tv[i].d_last;
         data_fifo_rden  = tv[i].d_rd;
         data_fifo_wdata = tv[i].d_dat;
         step();
         check($sformatf("v%0d c_empty", i), 128'(ctrl_fifo_empty), 128'(tv[i].x_cempty));
         check($sformatf("v%0d d_empty", i), 128'(data_fifo_empty), 128'(tv[i].x_dempty));
         if (tv[i].chk_c)
            check($sformatf("v%0d c_rdata", i), 128'(ctrl_fifo_rdata), 128'(tv[i].x_crd));
         if (tv[i].chk_d)
            check($sformatf("v%0d d_rdata", i), 128'(data_fifo_rdata), 128'(tv[i].x_drd));
      end
      idle_inputs();

      // Abort discards 5 uncommitted beats; abort also beats a simultaneous wlast write
      for (int i = 0; i < 5; i++) begin
         data_write(73'h300 + 73'(i), 1'b0);
         check($sformatf("abort pre%0d empty", i), 128'(data_fifo_empty), 128'(1'b1));
      end
      data_fifo_abort = 1'b1;
      data_write(73'h3FF, 1'b1);
      data_fifo_abort = 1'b0;
      check("abort empty", 128'(data_fifo_empty), 128'(1'b1));
      data_write(73'h310, 1'b0);
      check("abort f2b0 empty", 128'(data_fifo_empty), 128'(1'b1));
      data_write(73'h311, 1'b1);
      check("abort f2b1 empty", 128'(data_fifo_empty), 128'(1'b0));
      data_read("abort rd0", 73'h310, 1'b0);
      data_read("abort rd1", 73'h311, 1'b1);
`ifdef OFM_FIFO_STATS_EN
      check("abort frames", 128'(stat_frames), 128'(2));
      check("abort drops",  128'(stat_drops),  128'(1));
      check("abort ovf",    128'(stat_ovf),    128'(1'b0));
`endif

      // 20-beat frame into a 16-deep queue: overflow, rollback at wlast, no deadlock
      for (int i = 0; i < 20; i++) data_write(73'h400 + 73'(i), (i == 19));
      check("ovf empty", 128'(data_fifo_empty), 128'(1'b1));
      check("ovf afull lag", 128'(data_fifo_afull), 128'(1'b1));
      step();
      check("ovf afull clr", 128'(data_fifo_afull), 128'(1'b0));
`ifdef OFM_FIFO_STATS_EN
      check("ovf sticky", 128'(stat_ovf),   128'(1'b1));
      check("ovf drops",  128'(stat_drops), 128'(2));
      check("ovf frames", 128'(stat_frames), 128'(2));
`endif
      data_write(73'h4AA, 1'b1);
      check("post-ovf empty", 128'(data_fifo_empty), 128'(1'b0));
      data_read("post-ovf rd", 73'h4AA, 1'b1);
`ifdef OFM_FIFO_STATS_EN
      check("post-ovf frames", 128'(stat_frames), 128'(3));
`endif

      // ctrl almost-full: threshold 12 of 16, registered one cycle behind the count
      ctrl_fifo_wren = 1'b1;
      for (int i = 0; i < 11; i++) begin
         ctrl_fifo_wdata = 64'h100 + 64'(i);
         step();
      end
      ctrl_fifo_wren = 1'b0;
      step();
      check("c_afull at 11", 128'(ctrl_fifo_afull), 128'(1'b0));
      ctrl_fifo_wren  = 1'b1;
      ctrl_fifo_wdata = 64'h10B;
      step();
      ctrl_fifo_wren  = 1'b0;
      check("c_afull lag", 128'(ctrl_fifo_afull), 128'(1'b0));
      step();
      check("c_afull at 12", 128'(ctrl_fifo_afull), 128'(1'b1));
      ctrl_fifo_wren  = 1'b1;
      ctrl_fifo_rden  = 1'b1;
      ctrl_fifo_wdata = 64'h10C;
      step();
      ctrl_fifo_wren  = 1'b0;
      ctrl_fifo_rden  = 1'b0;
      check("c_pushpop rdata", 128'(ctrl_fifo_rdata), 128'(64'h100));
      step();
      check("c_pushpop afull", 128'(ctrl_fifo_afull), 128'(1'b1));
      for (int i = 1; i <= 12; i++) begin
         cexp = 64'h100 + 64'(i);
         ctrl_fifo_rden = 1'b1;
         step();
         check($sformatf("c_drain%0d", i), 128'(ctrl_fifo_rdata), 128'(cexp));
      end
      ctrl_fifo_rden = 1'b0;
      step();
      check("c_drain empty", 128'(ctrl_fifo_empty), 128'(1'b1));
      check("c_drain afull", 128'(ctrl_fifo_afull), 128'(1'b0));

      // Reset mid-frame with committed beats and a pending descriptor
      ctrl_fifo_wren  = 1'b1;
      ctrl_fifo_wdata = 64'h55;
      step();
      ctrl_fifo_wren  = 1'b0;
      for (int i = 0; i < 3; i++) data_write(73'h600 + 73'(i), (i == 2));
      data_fifo_wren  = 1'b1;
      data_fifo_wdata = 73'h6F0;
      step();
      check("pre-rst c_empty", 128'(ctrl_fifo_empty), 128'(1'b0));
      check("pre-rst d_empty", 128'(data_fifo_empty), 128'(1'b0));
      #2 mm2s_resetn = 1'b0;
      #1;
      check_reset_state("midrst");
      idle_inputs();
      step();
      #3 mm2s_resetn = 1'b1;
      data_write(73'h7E0, 1'b1);
      check("post-rst empty", 128'(data_fifo_empty), 128'(1'b0));
      data_read("post-rst rd", 73'h7E0, 1'b1);
      check("post-rst c_empty", 128'(ctrl_fifo_empty), 128'(1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
